// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over IReq/IAck, feeds decode via the IF/ID register; DELAY_SLOT_EN keeps the in-flight word on Redirect.
// Latency: a same-cycle IAck lands in Instruction on the next edge, so back-to-back fetch sustains one word per cycle.
// Backpressure: Stall freezes the IF/ID register; a word acked under Stall parks in a one-entry skid buffer and fetch pauses in HOLD.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IAck,
  input  logic [31:0] IData,
  output logic [31:0] Instruction,
  output logic [31:0] PCAddrIncOut,
  output logic        InstrValid
);

  typedef enum logic [1:0] {START, WAIT, HOLD, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] flush_addr, flush_addr_nxt;
  logic        skid_vld, skid_vld_nxt;
  logic [31:0] skid_dat, skid_dat_nxt;
  logic [31:0] skid_inc, skid_inc_nxt;
  logic [31:0] instr_nxt, inc_nxt;
  logic        vld_nxt;
  logic [31:0] target, pc_inc;
  logic        take;
  logic [31:0] take_inc;

  assign target = RedirectAddr & ~32'd3;
  assign pc_inc = pc + 32'd4;

  // FLUSH keeps presenting the superseded request until memory answers it
  assign IReq  = (state == WAIT) || (state == FLUSH);
  assign IAddr = (state == FLUSH) ? flush_addr : pc;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    flush_addr_nxt = flush_addr;
    skid_vld_nxt   = skid_vld;
    skid_dat_nxt   = skid_dat;
    skid_inc_nxt   = skid_inc;
    instr_nxt      = Instruction;
    inc_nxt        = PCAddrIncOut;
    vld_nxt        = InstrValid;
    take           = 1'b0;
    take_inc       = pc_inc;

    if (!Stall) begin
      instr_nxt = NOP_WORD;
      vld_nxt   = 1'b0;
    end

    case (state)
      START: state_nxt = WAIT;
      WAIT: begin
        if (IAck) begin
          take   = 1'b1;
          pc_nxt = pc_inc;
        end else if (Redirect) begin
          state_nxt      = FLUSH;
          flush_addr_nxt = pc;
        end
      end
      HOLD: begin
        if (!Stall) begin
          instr_nxt    = skid_dat;
          inc_nxt      = skid_inc;
          vld_nxt      = 1'b1;
          skid_vld_nxt = 1'b0;
          state_nxt    = WAIT;
        end
      end
      FLUSH: begin
        if (IAck) begin
          state_nxt = WAIT;
`ifdef DELAY_SLOT_EN
          // the pending word is the delay slot; PC already points at the target
          take     = 1'b1;
          take_inc = flush_addr + 32'd4;
`endif
        end
      end
    endcase

    if (take) begin
      if (Stall) begin
        skid_vld_nxt = 1'b1;
        skid_dat_nxt = IData;
        skid_inc_nxt = take_inc;
        state_nxt    = HOLD;
      end else begin
        instr_nxt = IData;
        inc_nxt   = take_inc;
        vld_nxt   = 1'b1;
        state_nxt = WAIT;
      end
    end

    if (Redirect) begin
      pc_nxt = target;
`ifdef DELAY_SLOT_EN
      // with nothing in flight there is no delay slot to honour
      if (!IReq) begin
        skid_vld_nxt = 1'b0;
        instr_nxt    = NOP_WORD;
        vld_nxt      = 1'b0;
        state_nxt    = WAIT;
      end
`else
      skid_vld_nxt = 1'b0;
      instr_nxt    = NOP_WORD;
      vld_nxt      = 1'b0;
      if (!(IReq && !IAck))
        state_nxt = WAIT;
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= START;
      pc           <= RESET_PC;
      flush_addr   <= RESET_PC;
      skid_vld     <= 1'b0;
      skid_dat     <= NOP_WORD;
      skid_inc     <= 32'd0;
      Instruction  <= NOP_WORD;
      PCAddrIncOut <= 32'd0;
      InstrValid   <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      flush_addr   <= flush_addr_nxt;
      skid_vld     <= skid_vld_nxt;
      skid_dat     <= skid_dat_nxt;
      skid_inc     <= skid_inc_nxt;
      Instruction  <= instr_nxt;
      PCAddrIncOut <= inc_nxt;
      InstrValid   <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level model (pending request, skid queue, PC) checked every cycle, plus literal scenario checks.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        Reset = 1'b0, Stall = 1'b0, Redirect = 1'b0, IAck = 1'b0;
  logic [31:0] RedirectAddr = '0, IData = '0;
  logic        IReq, InstrValid;
  logic [31:0] IAddr, Instruction, PCAddrIncOut;

  fetch_stage #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
    .Clock(clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
    .RedirectAddr(RedirectAddr), .IReq(IReq), .IAddr(IAddr), .IAck(IAck),
    .IData(IData), .Instruction(Instruction), .PCAddrIncOut(PCAddrIncOut),
    .InstrValid(InstrValid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  typedef struct packed { logic [31:0] d; logic [31:0] i; } ent_t;

  // model state: pc, one outstanding request, what happens to its reply, pending words
  logic [31:0] m_pc = RPC, m_raddr = RPC, m_instr = NOP, m_inc = '0;
  bit          m_req = 0, m_drop = 0, m_slot = 0, m_vld = 0;
  ent_t        skid[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit stall, input bit redir,
                            input logic [31:0] raddr, input bit ack, input logic [31:0] data);
    bit have, squash;
    logic [31:0] wd, wi;
    ent_t e;
    if (rst) begin
      m_pc = RPC; m_req = 0; m_drop = 0; m_slot = 0;
      skid.delete(); m_instr = NOP; m_inc = '0; m_vld = 0;
      return;
    end
    have = 0; squash = 0; wd = '0; wi = '0;
    if (m_req && ack) begin
      if (!m_drop) begin
        have = 1; wd = data; wi = m_raddr + 32'd4;
        if (!m_slot) m_pc = m_pc + 32'd4;
      end
      m_req = 0; m_drop = 0; m_slot = 0;
    end
    if (redir) begin
      m_pc = raddr & 32'hFFFF_FFFC;
`ifdef DELAY_SLOT_EN
      squash = !(have || m_req);
      if (m_req) m_slot = 1;
`else
      squash = 1; have = 0;
      if (m_req) m_drop = 1;
`endif
    end
    if (squash) begin
      skid.delete(); m_instr = NOP; m_vld = 0;
    end else if (have) begin
      if (!stall) begin m_instr = wd; m_inc = wi; m_vld = 1; end
      else begin e.d = wd; e.i = wi; skid.push_back(e); end
    end else if (!stall) begin
      if (skid.size() > 0) begin
        e = skid.pop_front(); m_instr = e.d; m_inc = e.i; m_vld = 1;
      end else begin
        m_instr = NOP; m_vld = 0;
      end
    end
    // fetch resumes whenever nothing is in flight and nothing is parked
    if (!m_req && skid.size() == 0) begin m_req = 1; m_raddr = m_pc; end
  endtask

  task automatic cycle(input bit rst, input bit stall, input bit redir,
                       input logic [31:0] raddr, input bit ack, input logic [31:0] data);
    Reset = rst; Stall = stall; Redirect = redir; RedirectAddr = raddr; IAck = ack; IData = data;
    @(posedge clk); #1;
    model_step(rst, stall, redir, raddr, ack, data);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ireq", IReq, m_req);
      if (m_req) chk("m_iaddr", IAddr, m_raddr);
      chk("m_vld", InstrValid, m_vld);
      chk("m_instr", Instruction, m_instr);
      if (m_vld) chk("m_pcinc", PCAddrIncOut, m_inc);
    end
  end

  initial begin
    int lat;
    bit armed;
    lat = 0; armed = 0;
    @(posedge clk); #1;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cmp_en = 1;
    chk("rst_ireq", IReq, 0);
    chk("rst_iaddr", IAddr, 32'h100);
    chk("rst_vld", InstrValid, 0);
    chk("rst_instr", Instruction, NOP);
    chk("rst_pcinc", PCAddrIncOut, 0);

    cycle(0, 0, 0, 0, 1, 32'hDEAD_BEEF);   // stray ack in START
    chk("start_ireq", IReq, 1);
    chk("start_iaddr", IAddr, 32'h100);
    chk("start_vld", InstrValid, 0);

    for (int i = 0; i < 4; i++) begin
      chk("b2b_iaddr", IAddr, 32'h100 + 4 * i);
      cycle(0, 0, 0, 0, 1, 32'hA000_0000 + i);
      chk("b2b_instr", Instruction, 32'hA000_0000 + i);
      chk("b2b_pcinc", PCAddrIncOut, 32'h104 + 4 * i);
      chk("b2b_vld", InstrValid, 1);
    end

    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk("dly_ireq", IReq, 1);
      chk("dly_iaddr", IAddr, 32'h110);
      chk("dly_vld", InstrValid, 0);
      chk("dly_instr", Instruction, NOP);
    end
    cycle(0, 0, 0, 0, 1, 32'hB000_0001);
    chk("dly_data", Instruction, 32'hB000_0001);
    chk("dly_pcinc", PCAddrIncOut, 32'h114);

    cycle(0, 1, 0, 0, 1, 32'hC000_0002);
    chk("hold_ireq", IReq, 0);
    chk("hold_instr", Instruction, 32'hB000_0001);
    cycle(0, 1, 0, 0, 0, 0);
    chk("hold_ireq2", IReq, 0);
    chk("hold_instr2", Instruction, 32'hB000_0001);
    chk("hold_vld", InstrValid, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rel_instr", Instruction, 32'hC000_0002);
    chk("rel_pcinc", PCAddrIncOut, 32'h118);
    chk("rel_ireq", IReq, 1);
    chk("rel_iaddr", IAddr, 32'h118);

    cycle(0, 0, 1, 32'h2003, 0, 0);
    chk("fl_ireq", IReq, 1);
    chk("fl_iaddr", IAddr, 32'h118);
    chk("fl_vld", InstrValid, 0);
    chk("fl_instr", Instruction, NOP);
    cycle(0, 0, 0, 0, 0, 0);
    chk("fl_iaddr2", IAddr, 32'h118);
    cycle(0, 0, 0, 0, 1, 32'hD000_0003);
`ifdef DELAY_SLOT_EN
    chk("ds_instr", Instruction, 32'hD000_0003);
    chk("ds_vld", InstrValid, 1);
    chk("ds_pcinc", PCAddrIncOut, 32'h11C);
`else
    chk("fl_drop_vld", InstrValid, 0);
    chk("fl_drop_instr", Instruction, NOP);
`endif
    chk("fl_tgt", IAddr, 32'h2000);

    cycle(0, 0, 1, 32'hFFFF_FFFE, 1, 32'hE000_0004);
    chk("wr_iaddr", IAddr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 1, 32'hF000_0005);
    chk("wr_instr", Instruction, 32'hF000_0005);
    chk("wr_pcinc", PCAddrIncOut, 32'h0);
    chk("wr_next", IAddr, 32'h0);

    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("mrst_ireq", IReq, 0);
    chk("mrst_iaddr", IAddr, 32'h100);
    chk("mrst_vld", InstrValid, 0);
    cycle(0, 0, 0, 0, 1, 32'h9999_9999);
    chk("late_vld", InstrValid, 0);
    chk("late_ireq", IReq, 1);
    chk("late_iaddr", IAddr, 32'h100);
    cycle(0, 0, 0, 0, 1, 32'h1234_5678);
    chk("post_instr", Instruction, 32'h1234_5678);
    chk("post_pcinc", PCAddrIncOut, 32'h104);

    for (int n = 0; n < 4000; n++) begin
      bit r, s, d, a;
      logic [31:0] ra;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 9) == 0);
      ra = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      if (m_req) begin
        if (!armed) begin lat = $urandom_range(0, 3); armed = 1; end
        a = (lat == 0);
        if (!a) lat--;
      end else begin
        a = ($urandom_range(0, 3) == 0);
      end
      if (a || r) armed = 0;
      cycle(r, s, d, ra, a, $urandom);
    end

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
